avalon_mm_arbiter: RTL

- Shares the single Avalon-MM slave bridge (SDRAM, LEDs, switches behind it) between the RISC-V core's instruction-fetch port (I) and data port (D).
- Each requester uses a simple req/ack interface. The block grants one requester at a time, round-robin on contention.
- Only one transaction is outstanding at a time. The block drives the bridge as an Avalon-MM master with burstcount 1.
- A watchdog returns an error if the bridge hangs.

---
 rtl/avalon_mm_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/avalon_mm_arbiter.sv
// Shares one Avalon-MM master between the instruction (I) and data (D) request ports.
// Round-robin on contention, one burstcount-1 transaction in flight, watchdog on a hung bridge.
module avalon_mm_arbiter #(
  parameter int                ADDR_W    = 28,
  parameter int                DATA_W    = 32,
  parameter int                TIMEOUT   = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,

  input  logic                i_req,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_be,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,

  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_burstcount,
  output logic                avm_debugaccess,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;

  state_t                state_q;
  logic                  last_d_q;
  logic                  gnt_d_q;
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   be_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [TW-1:0]         timer_q;
  logic                  stale_q;
  logic                  i_ack_q, d_ack_q;
  logic                  i_err_q, d_err_q;
  logic [DATA_W-1:0]     i_rdata_q, d_rdata_q;

  logic                  pick_d;
  logic                  win_we;
  logic [ADDR_W-1:0]     win_addr;
  logic [DATA_W-1:0]     win_wdata;
  logic [DATA_W/8-1:0]   win_be;
  logic                  expire;

  // D wins only if I is idle or I was granted last time.
  assign pick_d    = d_req & (~i_req | ~last_d_q);
  assign win_we    = pick_d ? d_we    : i_we;
  assign win_addr  = pick_d ? d_addr  : i_addr;
  assign win_wdata = pick_d ? d_wdata : i_wdata;
  assign win_be    = pick_d ? d_be    : i_be;

  // Fires on the edge that ends the TIMEOUT-th cycle spent in CMD+RESP.
  assign expire = (TIMEOUT != 0) && (timer_q >= T_LAST);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      timer_q   <= '0;
      stale_q   <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_err_q <= 1'b0;

      // The late answer to a timed-out read is swallowed wherever it shows up.
      if (avm_readdatavalid && stale_q) stale_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            gnt_d_q  <= pick_d;
            last_d_q <= pick_d;
            we_q     <= win_we;
            addr_q   <= win_addr;
            wdata_q  <= win_wdata;
            be_q     <= win_be;
            rd_q     <= ~win_we;
            wr_q     <= win_we;
            timer_q  <= '0;
            state_q  <= CMD;
          end
        end

        CMD: begin
          timer_q <= timer_q + TW'(1);
          if (!avm_waitrequest) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
            if (we_q) begin
              i_ack_q <= ~gnt_d_q;
              d_ack_q <= gnt_d_q;
              state_q <= DONE;
            end else begin
              state_q <= RESP;
            end
          end else if (expire) begin
            // Never accepted, so no response can follow: stale stays clear.
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            i_ack_q <= ~gnt_d_q;
            d_ack_q <= gnt_d_q;
            i_err_q <= ~gnt_d_q;
            d_err_q <= gnt_d_q;
            if (!we_q) begin
              if (gnt_d_q) d_rdata_q <= ERR_RDATA;
              else         i_rdata_q <= ERR_RDATA;
            end
            state_q <= DONE;
          end
        end

        RESP: begin
          timer_q <= timer_q + TW'(1);
          if (avm_readdatavalid && !stale_q) begin
            if (gnt_d_q) d_rdata_q <= avm_readdata;
            else         i_rdata_q <= avm_readdata;
            i_ack_q <= ~gnt_d_q;
            d_ack_q <= gnt_d_q;
            state_q <= DONE;
          end else if (expire) begin
            if (gnt_d_q) d_rdata_q <= ERR_RDATA;
            else         i_rdata_q <= ERR_RDATA;
            i_ack_q <= ~gnt_d_q;
            d_ack_q <= gnt_d_q;
            i_err_q <= ~gnt_d_q;
            d_err_q <= gnt_d_q;
            stale_q <= 1'b1;
            state_q <= DONE;
          end
        end

        DONE: state_q <= IDLE;

        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_ack           = i_ack_q;
  assign d_ack           = d_ack_q;
  assign i_err           = i_err_q;
  assign d_err           = d_err_q;
  assign i_rdata         = i_rdata_q;
  assign d_rdata         = d_rdata_q;
  assign avm_address     = addr_q;
  assign avm_read        = rd_q;
  assign avm_write       = wr_q;
  assign avm_writedata   = wdata_q;
  assign avm_byteenable  = be_q;
  assign avm_burstcount  = 1'b1;
  assign avm_debugaccess = 1'b0;

endmodule
